// File: rtl/sgdsp_top.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | sgdsp_top: sigma-delta ADC front end (comparator sync, feedback,         |
// | decimating counter, optional 4-sample averaging via SGDSP_AVG_EN)        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module sgdsp_top #(
  parameter int COUNT_WIDTH = 4,
  parameter int MAX_COUNT   = 6
) (
  input  logic                   CLK_i,
  input  logic                   RSTN_i,
  input  logic                   CMP_i,
  output logic                   FB_o,
  output logic [COUNT_WIDTH-1:0] SAMPLE_o,
  output logic                   SAMPLE_VALID_o,
  output logic [COUNT_WIDTH+1:0] AVG_o
);

  localparam logic [COUNT_WIDTH-1:0] c_last = COUNT_WIDTH'(MAX_COUNT - 1);

  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_fb;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic [COUNT_WIDTH-1:0] r_acc;
  logic [COUNT_WIDTH-1:0] r_sample;
  logic                   r_valid;
  logic                   w_last;
  logic [COUNT_WIDTH-1:0] w_new_sample;

  assign w_last       = (r_cnt == c_last);
  assign w_new_sample = r_acc + COUNT_WIDTH'(r_fb);

  // Comparator is asynchronous: two flops for metastability, one more for the feedback DAC bit.
  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_fb    <= 1'b0;
    end else begin
      r_sync1 <= CMP_i;
      r_sync2 <= r_sync1;
      r_fb    <= r_sync2;
    end
  end

  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_last) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_sample <= w_new_sample;
      end else begin
        r_cnt    <= r_cnt + 1'b1;
        r_acc    <= w_new_sample;
      end
    end
  end

  assign FB_o           = r_fb;
  assign SAMPLE_o       = r_sample;
  assign SAMPLE_VALID_o = r_valid;

`ifdef SGDSP_AVG_EN
  // Entry 0 is always the newest sample, so the sum tracks SAMPLE_o on the same edge.
  logic [3:0][COUNT_WIDTH-1:0] r_hist;

  always_ff @(posedge CLK_i or negedge RSTN_i) begin
    if (!RSTN_i) begin
      r_hist <= '0;
    end else if (w_last) begin
      r_hist <= {r_hist[2:0], w_new_sample};
    end
  end

  always_comb begin
    AVG_o = '0;
    for (int i = 0; i < 4; i++) begin
      AVG_o = AVG_o + (COUNT_WIDTH+2)'(r_hist[i]);
    end
  end
`else
  assign AVG_o = {r_sample, 2'b00};
`endif

endmodule
`default_nettype wire

// File: tb/tb_sgdsp_top.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sgdsp_top: scoreboard bench for sgdsp_top (COUNT_WIDTH=4, MAX=6)      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_sgdsp_top;

  localparam int CW = 4;
  localparam int MC = 6;

  logic          CLK_i  = 1'b0;
  logic          RSTN_i = 1'b0;
  logic          CMP_i  = 1'b0;
  logic          FB_o;
  logic [CW-1:0] SAMPLE_o;
  logic          SAMPLE_VALID_o;
  logic [CW+1:0] AVG_o;

  sgdsp_top #(
    .COUNT_WIDTH(CW),
    .MAX_COUNT  (MC)
  ) dut (
    .CLK_i         (CLK_i),
    .RSTN_i        (RSTN_i),
    .CMP_i         (CMP_i),
    .FB_o          (FB_o),
    .SAMPLE_o      (SAMPLE_o),
    .SAMPLE_VALID_o(SAMPLE_VALID_o),
    .AVG_o         (AVG_o)
  );

  always #41.667 CLK_i = ~CLK_i;

  typedef struct {
    int sample;
    int avg;
    int gap;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edges    = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: counts edges since reset release / last strobe and checks each strobe.
  always @(posedge CLK_i) begin
    exp_t e;
    #1;
    if (!RSTN_i) edges = 0;
    else         edges++;
    if (SAMPLE_VALID_o) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe with SAMPLE_o=%0d, expected no strobe (t=%0t)",
                 SAMPLE_o, $time);
      end else begin
        e = q.pop_front();
        check("sample", int'(SAMPLE_o), e.sample);
        check("avg", int'(AVG_o), e.avg);
        check("strobe_gap", edges, e.gap);
      end
      edges = 0;
    end
  end

  task automatic tick();
    @(negedge CLK_i);
  endtask

  task automatic reset_release();
    @(negedge CLK_i);
    RSTN_i = 1'b0;
    repeat (3) @(negedge CLK_i);
    RSTN_i = 1'b1;
  endtask

  task automatic push(input int s, input int avg_en, input int avg_dis);
    exp_t e;
    e.sample = s;
`ifdef SGDSP_AVG_EN
    e.avg = avg_en;
`else
    e.avg = avg_dis;
`endif
    e.gap = MC;
    q.push_back(e);
  endtask

  task automatic drain_check(input string name);
    check(name, q.size(), 0);
  endtask

  initial begin
    // Reset held with the comparator toggling.
    for (int i = 0; i < 8; i++) begin
      tick();
      check("reset_outputs", int'({FB_o, SAMPLE_VALID_o, SAMPLE_o, AVG_o}), 0);
      CMP_i = ~CMP_i;
    end

    // Constant high: first window holds 3 reset-zero sync cycles.
    reset_release();
    CMP_i = 1'b1;
    push(3, 3, 12);
    push(6, 9, 24);
    push(6, 15, 24);
    push(6, 21, 24);
    push(6, 24, 24);
    tick(); tick();
    check("fb_latency_2", int'(FB_o), 0);
    tick();
    check("fb_latency_3", int'(FB_o), 1);
    repeat (27) tick();
    drain_check("high_drained");
    repeat (3) tick();
    check("sample_hold", int'(SAMPLE_o), 6);

    // Constant low.
    reset_release();
    CMP_i = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 0, 0);
    repeat (18) tick();
    drain_check("low_drained");

    // Alternating input, 1 before edge 1.
    reset_release();
    CMP_i = 1'b1;
    push(2, 2, 8);
    push(3, 5, 12);
    push(3, 8, 12);
    push(3, 11, 12);
    for (int k = 1; k <= 24; k++) begin
      tick();
      CMP_i = (k % 2 == 0);
    end
    drain_check("alt_drained");

    // Averaging ramp: ones reach FB_o exactly at the start of window 5.
    reset_release();
    CMP_i = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 0, 0);
    push(6, 6, 24);
    push(6, 12, 24);
    push(6, 18, 24);
    push(6, 24, 24);
    push(6, 24, 24);
    for (int k = 1; k <= 54; k++) begin
      tick();
      if (k == 21) CMP_i = 1'b1;
    end
    drain_check("ramp_drained");

    // Mid-window reset at counter=3.
    reset_release();
    CMP_i = 1'b1;
    push(3, 3, 12);
    push(6, 9, 24);
    repeat (12) tick();
    drain_check("mid_pre_drained");
    repeat (3) tick();
    check("mid_pre_sample", int'(SAMPLE_o), 6);
    RSTN_i = 1'b0;
    #1;
    check("mid_reset_clear", int'({FB_o, SAMPLE_VALID_o, SAMPLE_o, AVG_o}), 0);
    tick();
    RSTN_i = 1'b1;
    push(3, 3, 12);
    push(6, 9, 24);
    repeat (12) tick();
    drain_check("mid_post_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout at t=%0t, expected completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

endmodule
`default_nettype wire
